char_input_queue: RTL and testbench

CHAR_INPUT_QUEUE -- requirements
Module: char_input_queue

---
 rtl/char_queue_pkg.sv | 19 +
 rtl/char_fifo.sv | 76 +++++++
 rtl/char_input_queue.sv | 126 ++++++++++++
 tb/tb_char_input_queue.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/char_queue_pkg.sv
// Shared types and defaults for the character input queue.
package char_queue_pkg;

  localparam int DEFAULT_DEPTH  = 8;
  localparam int DEFAULT_DATA_W = 5;

  typedef logic [DEFAULT_DATA_W-1:0] char_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HELD   = 2'd1,
    REPEAT = 2'd2
  } press_state_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/char_fifo.sv
// Circular FIFO holding committed characters; head is shown combinationally from the storage registers.
module char_fifo
  import char_queue_pkg::*;
#(
  parameter int DEPTH  = DEFAULT_DEPTH,
  parameter int DATA_W = DEFAULT_DATA_W
) (
  input  logic                       clk_in,
  input  logic                       rst_in,
  input  logic                       clear_in,
  input  logic                       push_in,
  input  logic                       pop_in,
  input  logic [DATA_W-1:0]          data_in,
  output logic [DATA_W-1:0]          data_out,
  output logic                       valid_out,
  output logic                       full_out,
  output logic [$clog2(DEPTH+1)-1:0] count_out
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              empty, full, do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CNT_W'(DEPTH));
  assign do_pop  = pop_in && !empty;
  // A pop on the same edge frees the slot the push is about to use.
  assign do_push = push_in && (!full || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clear_in) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is never reset; an empty queue masks whatever it holds.
  always_ff @(posedge clk_in) begin
    if (do_push && !clear_in) mem_q[wr_ptr_q] <= data_in;
  end

  assign data_out  = empty ? '0 : mem_q[rd_ptr_q];
  assign valid_out = !empty;
  assign full_out  = full;
  assign count_out = count_q;

endmodule

// File: rtl/char_input_queue.sv
// Button-driven character queue: edge detect, press FSM, overflow flag and flush around char_fifo.
// Define CHAR_INPUT_QUEUE_AUTOREPEAT_EN to enable auto-repeat while the button is held.
module char_input_queue
  import char_queue_pkg::*;
#(
  parameter int DEPTH         = DEFAULT_DEPTH,
  parameter int DATA_W        = DEFAULT_DATA_W,
  parameter int REPEAT_DELAY  = 50_000_000,
  parameter int REPEAT_PERIOD = 10_000_000
) (
  input  logic                       clk_in,
  input  logic                       rst_in,
  input  logic                       commit_in,
  input  logic [DATA_W-1:0]          char_in,
  input  logic                       clear_in,
  input  logic                       ready_in,
  output logic                       data_valid_out,
  output logic [DATA_W-1:0]          data_out,
  output logic [$clog2(DEPTH+1)-1:0] count_out,
  output logic                       overflow_out
);

  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0) || (REPEAT_DELAY < 1) || (REPEAT_PERIOD < 1)) begin : g_bad_params
    $error("char_input_queue: DEPTH must be a power of two >= 2 and repeat timings >= 1");
  end

  logic         commit_q;
  logic         push_req, fifo_push, fifo_pop, fifo_full;
  logic         overflow_q, overflow_d;
  press_state_t state_q, state_d;

  assign push_req = commit_in && !commit_q;
  assign fifo_pop = data_valid_out && ready_in;

`ifdef CHAR_INPUT_QUEUE_AUTOREPEAT_EN
  localparam int CNT_W = max_int(1, $clog2(max_int(REPEAT_DELAY, REPEAT_PERIOD)));

  logic [CNT_W-1:0] rpt_cnt_q, rpt_cnt_d;
  logic             rpt_push;

  always_comb begin
    state_d   = state_q;
    rpt_cnt_d = rpt_cnt_q + CNT_W'(1);
    rpt_push  = 1'b0;
    case (state_q)
      IDLE: begin
        rpt_cnt_d = '0;
        if (push_req) state_d = HELD;
      end
      HELD: begin
        if (!commit_in) begin
          state_d = IDLE;
        end else if (rpt_cnt_q == CNT_W'(REPEAT_DELAY - 1)) begin
          state_d  = REPEAT;
          rpt_push = 1'b1;
        end
      end
      REPEAT: begin
        if (!commit_in) begin
          state_d = IDLE;
        end else if (rpt_cnt_q == CNT_W'(REPEAT_PERIOD - 1)) begin
          rpt_push  = 1'b1;
          rpt_cnt_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
    if (state_d != state_q) rpt_cnt_d = '0;
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) rpt_cnt_q <= '0;
    else         rpt_cnt_q <= rpt_cnt_d;
  end

  assign fifo_push = push_req || rpt_push;
`else
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (push_req) state_d = HELD;
      default: if (!commit_in) state_d = IDLE;
    endcase
  end

  assign fifo_push = push_req;
`endif

  always_comb begin
    overflow_d = overflow_q;
    if (clear_in)                                 overflow_d = 1'b0;
    else if (fifo_push && fifo_full && !fifo_pop) overflow_d = 1'b1;
  end

  // commit_q comes out of reset high so a button held through reset is not a new press.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      commit_q   <= 1'b1;
      state_q    <= IDLE;
      overflow_q <= 1'b0;
    end else begin
      commit_q   <= commit_in;
      state_q    <= state_d;
      overflow_q <= overflow_d;
    end
  end

  char_fifo #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W)
  ) u_fifo (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .clear_in  (clear_in),
    .push_in   (fifo_push),
    .pop_in    (fifo_pop),
    .data_in   (char_in),
    .data_out  (data_out),
    .valid_out (data_valid_out),
    .full_out  (fifo_full),
    .count_out (count_out)
  );

  assign overflow_out = overflow_q;

endmodule

// File: tb/tb_char_input_queue.sv
// Directed bench for char_input_queue with a queue-based reference model checked every cycle.
module tb_char_input_queue;

  localparam int DEPTH  = 8;
  localparam int DATA_W = 5;
  localparam int RD     = 10;
  localparam int RP     = 4;
  localparam int CW     = $clog2(DEPTH+1);
`ifdef CHAR_INPUT_QUEUE_AUTOREPEAT_EN
  localparam bit AUTOREP = 1'b1;
`else
  localparam bit AUTOREP = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              commit = 1'b0;
  logic              clear = 1'b0;
  logic              ready = 1'b0;
  logic [DATA_W-1:0] chr = '0;
  logic              dv;
  logic [DATA_W-1:0] dout;
  logic [CW-1:0]     cnt;
  logic              ovf;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  char_input_queue #(
    .DEPTH         (DEPTH),
    .DATA_W        (DATA_W),
    .REPEAT_DELAY  (RD),
    .REPEAT_PERIOD (RP)
  ) dut (
    .clk_in         (clk),
    .rst_in         (rst_n),
    .commit_in      (commit),
    .char_in        (chr),
    .clear_in       (clear),
    .ready_in       (ready),
    .data_valid_out (dv),
    .data_out       (dout),
    .count_out      (cnt),
    .overflow_out   (ovf)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: a press pushes once, holding adds pushes at RD, RD+RP, RD+2RP... cycles.
  logic [DATA_W-1:0] mq[$];
  bit m_ovf = 1'b0;
  bit m_prev = 1'b1;
  bit m_pressed = 1'b0;
  int m_held = 0;

  always @(posedge clk) begin : model
    bit push;
    bit pop;
    int sz;
    if (!rst_n) begin
      mq.delete();
      m_ovf = 1'b0;
      m_prev = 1'b1;
      m_pressed = 1'b0;
      m_held = 0;
    end else begin
      push = 1'b0;
      if (commit && !m_prev) begin
        push = 1'b1;
        m_pressed = 1'b1;
        m_held = 0;
      end else if (commit && m_pressed) begin
        m_held++;
        if (AUTOREP && m_held >= RD && ((m_held - RD) % RP) == 0) push = 1'b1;
      end else if (!commit) begin
        m_pressed = 1'b0;
        m_held = 0;
      end
      m_prev = commit;
      sz = mq.size();
      pop = (sz != 0) && ready;
      if (clear) begin
        mq.delete();
        m_ovf = 1'b0;
      end else begin
        if (pop) void'(mq.pop_front());
        if (push) begin
          if (sz < DEPTH || pop) mq.push_back(chr);
          else m_ovf = 1'b1;
        end
      end
    end
  end

  always @(posedge clk) begin : compare
    logic [DATA_W-1:0] exp_d;
    #1;
    exp_d = (mq.size() != 0) ? mq[0] : '0;
    check("model_valid", 32'(dv), 32'(mq.size() != 0));
    check("model_data", 32'(dout), 32'(exp_d));
    check("model_count", 32'(cnt), 32'(mq.size()));
    check("model_overflow", 32'(ovf), 32'(m_ovf));
  end

  task automatic press(input logic [DATA_W-1:0] c);
    chr = c;
    commit = 1'b1;
    @(negedge clk);
    commit = 1'b0;
    @(negedge clk);
    $display("[TB] press char=0x%02h count=%0d overflow=%0b", c, cnt, ovf);
  endtask

  task automatic do_clear();
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    @(negedge clk);
    $display("[TB] clear count=%0d overflow=%0b", cnt, ovf);
  endtask

  task automatic pop_all(input logic [DATA_W-1:0] exp_seq[DEPTH], input string name);
    ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      check(name, 32'(dout), 32'(exp_seq[i]));
      $display("[TB] pop char=0x%02h", dout);
      @(negedge clk);
    end
    ready = 1'b0;
    check({name, "_empty"}, 32'(cnt), 32'd0);
  endtask

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    logic [DATA_W-1:0] seq[DEPTH];

    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_count", 32'(cnt), 32'd0);
    check("reset_valid", 32'(dv), 32'd0);
    check("reset_data", 32'(dout), 32'd0);
    check("reset_overflow", 32'(ovf), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // single commit, 1-cycle latency
    chr = 5'h0A;
    commit = 1'b1;
    @(negedge clk);
    check("first_valid", 32'(dv), 32'd1);
    check("first_data", 32'(dout), 32'h0A);
    check("first_count", 32'(cnt), 32'd1);
    commit = 1'b0;
    @(negedge clk);
    do_clear();

    // overflow on the ninth commit
    for (int i = 1; i <= 9; i++) press(DATA_W'(i));
    check("ovf_count", 32'(cnt), 32'd8);
    check("ovf_flag", 32'(ovf), 32'd1);
    for (int i = 0; i < DEPTH; i++) seq[i] = DATA_W'(i + 1);
    pop_all(seq, "ovf_pop");
    check("ovf_sticky", 32'(ovf), 32'd1);
    do_clear();
    check("clear_ovf", 32'(ovf), 32'd0);

    // full, then push and pop on the same edge
    for (int i = 0; i < DEPTH; i++) press(DATA_W'(5'h11 + i));
    check("full_count", 32'(cnt), 32'd8);
    chr = 5'h1F;
    commit = 1'b1;
    ready = 1'b1;
    @(negedge clk);
    commit = 1'b0;
    ready = 1'b0;
    check("fullpp_count", 32'(cnt), 32'd8);
    check("fullpp_ovf", 32'(ovf), 32'd0);
    @(negedge clk);
    for (int i = 0; i < DEPTH - 1; i++) seq[i] = DATA_W'(5'h12 + i);
    seq[DEPTH-1] = 5'h1F;
    pop_all(seq, "fullpp_pop");

    // clear wins over a same-edge commit
    press(5'h03);
    press(5'h04);
    press(5'h05);
    check("pre_clear_count", 32'(cnt), 32'd3);
    chr = 5'h15;
    commit = 1'b1;
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    commit = 1'b0;
    check("clrpush_count", 32'(cnt), 32'd0);
    check("clrpush_valid", 32'(dv), 32'd0);
    check("clrpush_ovf", 32'(ovf), 32'd0);
    @(negedge clk);

    // long hold: auto-repeat pushes when enabled
    chr = 5'h07;
    commit = 1'b1;
    repeat (25) @(negedge clk);
    commit = 1'b0;
    repeat (2) @(negedge clk);
    check("hold_pushes", 32'(cnt), AUTOREP ? 32'd5 : 32'd1);
    $display("[TB] hold 25 cycles count=%0d", cnt);
    do_clear();

    // reset mid-burst with the button held through release
    press(5'h01);
    press(5'h02);
    commit = 1'b1;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("midreset_count", 32'(cnt), 32'd0);
    check("midreset_valid", 32'(dv), 32'd0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("held_release_count", 32'(cnt), 32'd0);
    commit = 1'b0;
    @(negedge clk);
    check("held_fall_count", 32'(cnt), 32'd0);
    chr = 5'h0C;
    commit = 1'b1;
    @(negedge clk);
    check("repress_count", 32'(cnt), 32'd1);
    check("repress_data", 32'(dout), 32'h0C);
    commit = 1'b0;
    repeat (2) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
